control_unit_mc: RTL and testbench

//  Parametrised successor to the single-bus processor sequencer: a multi-cycle FSM that decodes IR and drives bus/ALU/GPR/RAM/UART strobes.

---
 rtl/cu_pkg.sv | 72 +++++++
 rtl/cu_timeout_ctr.sv | 34 +++
 rtl/control_unit_mc.sv | 210 +++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings for the multi-cycle control unit
package cu_pkg;

    localparam int STATE_W = 5;

    localparam logic [4:0] S_IDLE    = 5'd0;
    localparam logic [4:0] S_F1      = 5'd1;
    localparam logic [4:0] S_F2      = 5'd2;
    localparam logic [4:0] S_F3      = 5'd3;
    localparam logic [4:0] S_E0_1    = 5'd4;
    localparam logic [4:0] S_E0_2    = 5'd5;   // add
    localparam logic [4:0] S_E1_2    = 5'd6;   // sub
    localparam logic [4:0] S_E2_2    = 5'd7;   // and
    localparam logic [4:0] S_E3_2    = 5'd8;   // or
    localparam logic [4:0] S_E0_3    = 5'd9;
    localparam logic [4:0] S_E4_1    = 5'd10;  // not
    localparam logic [4:0] S_E5_L    = 5'd11;  // shift left
    localparam logic [4:0] S_E5_R    = 5'd12;  // shift right
    localparam logic [4:0] S_E6_1    = 5'd13;
    localparam logic [4:0] S_E7_1    = 5'd14;
    localparam logic [4:0] S_E7_2    = 5'd15;
    localparam logic [4:0] S_E8_2    = 5'd16;
    localparam logic [4:0] S_E11_1   = 5'd17;
    localparam logic [4:0] S_E12_1   = 5'd18;
    localparam logic [4:0] S_E12_2   = 5'd19;
    localparam logic [4:0] S_E13_1   = 5'd20;
    localparam logic [4:0] S_E14_1   = 5'd21;
    localparam logic [4:0] S_WAIT    = 5'd22;
    localparam logic [4:0] S_E14_3   = 5'd23;
    localparam logic [4:0] S_E15_1   = 5'd24;
    localparam logic [4:0] S_E15_2   = 5'd25;
    localparam logic [4:0] S_HALT    = 5'd26;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_AND    = 3'd1;
    localparam logic [2:0] ALU_INCY1  = 3'd2;
    localparam logic [2:0] ALU_NOT    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_PASSY  = 3'd5;
    localparam logic [2:0] ALU_SUB    = 3'd6;
    localparam logic [2:0] ALU_ADDDEC = 3'd7;

    localparam int SEL_NONE = 0;
    localparam int SEL_PC   = 1;
    localparam int SEL_RD1  = 2;
    localparam int SEL_RD2  = 3;
    localparam int SEL_RS1  = 4;
    localparam int SEL_RS2  = 5;

    localparam int CTRL_W    = 20;
    localparam int C_GPR_IN  = 0;
    localparam int C_GPR_OUT = 1;
    localparam int C_IR_IN   = 2;
    localparam int C_IR_OUT  = 3;
    localparam int C_MAR_IN  = 4;
    localparam int C_MDR_IN  = 5;
    localparam int C_MDR_OUT = 6;
    localparam int C_RAM_RD  = 7;
    localparam int C_RAM_WR  = 8;
    localparam int C_UART_TX = 9;
    localparam int C_UART_OUT = 10;
    localparam int C_UART_RX = 11;
    localparam int C_Y_IN    = 12;
    localparam int C_Y_OUT   = 13;
    localparam int C_Y_OFF   = 14;
    localparam int C_Y_SHL   = 15;
    localparam int C_Y_SHR   = 16;
    localparam int C_Z_IN    = 17;
    localparam int C_Z_OUT   = 18;
    localparam int C_SPARE   = 19;

endpackage

// File: rtl/cu_timeout_ctr.sv
// rtl/cu_timeout_ctr.sv - load/enable counter with terminal count for UART waits
module cu_timeout_ctr #(
    parameter int LIMIT = 4095,
    parameter int W     = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    // Clear on load, otherwise count enabled cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // tc marks the enabled cycle that completes LIMIT cycles; LIMIT of 0 never fires
    always_comb begin
        tc = 1'b0;
        if (LIMIT != 0 && en) begin
            tc = (({1'b0, count} + 1'b1) == (W+1)'(LIMIT));
        end
    end

endmodule

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle instruction sequencer with stalls, UART timeout and debug halt
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int RS2_LSB  = 0,
    parameter int SEL_W    = 3,
    parameter int UART_TMO = 4095,
    parameter int TMO_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          PSW_bits,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                mem_ready,
    input  logic                uart_done,
    input  logic                dbg_resume,
    input  logic                dbg_step,
    output logic [2:0]          ALU_control,
    output logic [SEL_W-1:0]    GPR_select,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                halted,
    output logic                uart_timeout,
    output logic [STATE_W-1:0]  state_dbg
);

    logic [STATE_W-1:0] state, next_state, end_state;
    logic [3:0]         opcode;
    logic [SEL_W-1:0]   rs2;
    logic               halt_lock;
    logic               in_wait, tmo_hit;

    assign opcode    = instruction[INSTR_W-1 -: 4];
    assign rs2       = instruction[RS2_LSB +: SEL_W];
    assign end_state = dbg_step ? S_HALT : S_F1;
    assign in_wait   = (state == S_WAIT);
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

    cu_timeout_ctr #(.LIMIT(UART_TMO), .W(TMO_W)) u_tmo (
        .clk   (clk),
        .reset (reset),
        .load  (!in_wait),
        .en    (in_wait),
        .tc    (tmo_hit)
    );

    // State register, halt-forever latch for instruction 0 and sticky UART abort flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            halt_lock    <= 1'b0;
            uart_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_F3 && instruction == '0) begin
                halt_lock <= 1'b1;
            end
            if (in_wait && !uart_done && tmo_hit) begin
                uart_timeout <= 1'b1;
            end else if (halted && dbg_resume && !halt_lock) begin
                uart_timeout <= 1'b0;
            end
        end
    end

    // Next-state: fetch, decode on opcode, memory stalls, UART wait and debug halt
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_F1;
            S_F1:    if (mem_ready) next_state = S_F2;
            S_F2:    next_state = S_F3;
            S_F3: begin
                if (instruction == '0) begin
                    next_state = S_HALT;
                end else begin
                    case (opcode)
                        4'd0, 4'd1, 4'd2, 4'd3: next_state = S_E0_1;
                        4'd4:        next_state = S_E4_1;
                        4'd5:        next_state = (rs2 == '0) ? S_E5_L : S_E5_R;
                        4'd6:        next_state = S_E6_1;
                        4'd7, 4'd8:  next_state = S_E7_1;
                        4'd9:        next_state = PSW_bits[1] ? S_E11_1 : end_state;
                        4'd10:       next_state = PSW_bits[0] ? S_E11_1 : end_state;
                        4'd11:       next_state = S_E11_1;
                        4'd12:       next_state = S_E12_1;
                        4'd13:       next_state = S_E13_1;
                        4'd14:       next_state = S_E14_1;
                        default:     next_state = S_E15_1;
                    endcase
                end
            end
            S_E0_1: begin
                case (opcode)
                    4'd0:    next_state = S_E0_2;
                    4'd1:    next_state = S_E1_2;
                    4'd2:    next_state = S_E2_2;
                    default: next_state = S_E3_2;
                endcase
            end
            S_E0_2, S_E1_2, S_E2_2, S_E3_2, S_E4_1, S_E5_L, S_E5_R: next_state = S_E0_3;
            S_E0_3, S_E6_1, S_E7_2, S_E11_1: next_state = end_state;
            S_E7_1:  if (mem_ready) next_state = (opcode == 4'd7) ? S_E7_2 : S_E8_2;
            S_E8_2, S_E14_3: if (mem_ready) next_state = end_state;
            S_E12_1: next_state = S_E12_2;
            S_E12_2: next_state = S_E11_1;
            S_E13_1: next_state = S_E11_1;
            S_E14_1: next_state = S_WAIT;
            S_E15_1: if (mem_ready) next_state = S_E15_2;
            S_E15_2: next_state = S_WAIT;
            S_WAIT: begin
                if (uart_done) begin
                    next_state = (opcode == 4'd14) ? S_E14_3 : end_state;
                end else if (tmo_hit) begin
                    next_state = S_HALT;
                end
            end
            S_HALT:  if (dbg_resume && !halt_lock) next_state = S_F1;
            default: next_state = S_IDLE;
        endcase
    end

    // Moore output decode: strobes, ALU op and register select from state alone
    always_comb begin
        ctrl        = '0;
        ALU_control = ALU_ADD;
        GPR_select  = SEL_W'(SEL_NONE);
        case (state)
            S_F1: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; ctrl[C_Z_IN] = 1'b1;
                ctrl[C_MAR_IN]  = 1'b1; ctrl[C_RAM_RD] = 1'b1;
                ALU_control = ALU_INCY1;
                GPR_select  = SEL_W'(SEL_PC);
            end
            S_F2: begin
                ctrl[C_IR_IN] = 1'b1; ctrl[C_MDR_OUT] = 1'b1; ctrl[C_Y_OFF] = 1'b1;
            end
            S_F3, S_E11_1: begin
                ctrl[C_Z_OUT] = 1'b1; ctrl[C_GPR_IN] = 1'b1;
                ALU_control = ALU_ADDDEC;
                GPR_select  = SEL_W'(SEL_PC);
            end
            S_E0_1: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RS2);
            end
            S_E0_2, S_E1_2, S_E2_2, S_E3_2, S_E4_1, S_E5_L, S_E5_R: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_Z_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RS1);
                case (state)
                    S_E1_2:  ALU_control = ALU_SUB;
                    S_E2_2:  ALU_control = ALU_AND;
                    S_E3_2:  ALU_control = ALU_OR;
                    S_E4_1:  ALU_control = ALU_NOT;
                    S_E5_L:  begin ALU_control = ALU_PASSY; ctrl[C_Y_SHL] = 1'b1; end
                    S_E5_R:  begin ALU_control = ALU_PASSY; ctrl[C_Y_SHR] = 1'b1; end
                    default: ALU_control = ALU_ADD;
                endcase
            end
            S_E0_3: begin
                ctrl[C_Z_OUT] = 1'b1; ctrl[C_GPR_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RD1);
            end
            S_E6_1: begin
                ctrl[C_IR_OUT] = 1'b1; ctrl[C_GPR_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RD1);
            end
            S_E7_1, S_E15_1: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_MAR_IN] = 1'b1; ctrl[C_RAM_RD] = 1'b1;
                GPR_select = SEL_W'(SEL_RS1);
            end
            S_E7_2: begin
                ctrl[C_MDR_OUT] = 1'b1; ctrl[C_GPR_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RD1);
            end
            S_E8_2: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_MDR_IN] = 1'b1; ctrl[C_RAM_WR] = 1'b1;
                GPR_select = SEL_W'(SEL_RD2);
            end
            S_E12_1: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_PC);
            end
            S_E12_2: begin
                ctrl[C_Y_OUT] = 1'b1; ctrl[C_GPR_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RD1);
            end
            S_E13_1: begin
                ctrl[C_GPR_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; ctrl[C_Z_IN] = 1'b1;
                ALU_control = ALU_PASSY;
                GPR_select  = SEL_W'(SEL_RS1);
            end
            S_E14_1: begin
                ctrl[C_UART_RX] = 1'b1; ctrl[C_GPR_OUT] = 1'b1; ctrl[C_MAR_IN] = 1'b1;
                GPR_select = SEL_W'(SEL_RS1);
            end
            S_E14_3: begin
                ctrl[C_UART_OUT] = 1'b1; ctrl[C_MDR_IN] = 1'b1; ctrl[C_RAM_WR] = 1'b1;
            end
            S_E15_2: begin
                ctrl[C_MDR_OUT] = 1'b1; ctrl[C_UART_TX] = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - directed self-checking bench for control_unit_mc
module tb_control_unit_mc;
    import cu_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  PSW_bits;
    logic [15:0] instruction;
    logic        mem_ready, uart_done, dbg_resume, dbg_step;
    logic [2:0]  ALU_control;
    logic [2:0]  GPR_select;
    logic [19:0] ctrl;
    logic        halted, uart_timeout;
    logic [4:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    control_unit_mc #(
        .INSTR_W(16), .RS2_LSB(0), .SEL_W(3), .UART_TMO(8), .TMO_W(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PSW_bits     (PSW_bits),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .uart_done    (uart_done),
        .dbg_resume   (dbg_resume),
        .dbg_step     (dbg_step),
        .ALU_control  (ALU_control),
        .GPR_select   (GPR_select),
        .ctrl         (ctrl),
        .halted       (halted),
        .uart_timeout (uart_timeout),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; instruction = 16'h1234; PSW_bits = 2'b00;
        mem_ready = 1'b0; uart_done = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
        tick(); tick();
        checks++;
        if (state_dbg !== 5'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        checks++;
        if ({ctrl, ALU_control, GPR_select, halted, uart_timeout} !== 28'd0)
            begin errors++; $display("FAIL reset_outputs got %0h want 0", {ctrl, ALU_control, GPR_select, halted, uart_timeout}); end
        reset = 1'b1;
        tick();
        checks++;
        if (state_dbg !== S_F1) begin errors++; $display("FAIL reset_release got %0d want %0d", state_dbg, S_F1); end
    endtask

    task automatic test_alu;
        logic [4:0]  exp_s [7];
        logic [19:0] f1_exp;
        exp_s = '{S_F1, S_F2, S_F3, S_E0_1, S_E0_2, S_E0_3, S_F1};
        f1_exp = '0;
        f1_exp[C_GPR_OUT] = 1'b1; f1_exp[C_Y_IN] = 1'b1; f1_exp[C_Z_IN] = 1'b1;
        f1_exp[C_MAR_IN] = 1'b1; f1_exp[C_RAM_RD] = 1'b1;
        instruction = 16'h0123; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (state_dbg !== exp_s[i]) begin errors++; $display("FAIL alu_seq[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
            if (i == 0) begin
                checks++;
                if ({ctrl, ALU_control, GPR_select} !== {f1_exp, 3'd2, 3'd1})
                    begin errors++; $display("FAIL f1_strobes got %0h/%0d/%0d want %0h/2/1", ctrl, ALU_control, GPR_select, f1_exp); end
            end
            if (i == 4) begin
                checks++;
                if (ALU_control !== 3'd0 || GPR_select !== 3'd4)
                    begin errors++; $display("FAIL e0_2_alu_sel got %0d/%0d want 0/4", ALU_control, GPR_select); end
            end
        end
    endtask

    task automatic test_stall;
        logic [4:0] exp_s [4];
        exp_s = '{S_F1, S_F2, S_F3, S_E7_1};
        instruction = 16'h7210; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (state_dbg !== exp_s[i]) begin errors++; $display("FAIL stall_seq[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state_dbg !== S_E7_1 || ctrl[C_RAM_RD] !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d] got %0d rd=%0b want %0d rd=1", i, state_dbg, ctrl[C_RAM_RD], S_E7_1); end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        checks++;
        if (state_dbg !== S_E7_2) begin errors++; $display("FAIL stall_release got %0d want %0d", state_dbg, S_E7_2); end
        tick();
        checks++;
        if (state_dbg !== S_F1) begin errors++; $display("FAIL load_end got %0d want %0d", state_dbg, S_F1); end
    endtask

    task automatic test_branch;
        logic [4:0]  exp_s [8];
        logic [19:0] br_exp;
        exp_s = '{S_F1, S_F2, S_F3, S_F1, S_F2, S_F3, S_E11_1, S_F1};
        br_exp = '0; br_exp[C_Z_OUT] = 1'b1; br_exp[C_GPR_IN] = 1'b1;
        instruction = 16'h9000; PSW_bits = 2'b00; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (state_dbg !== exp_s[i]) begin errors++; $display("FAIL branch_seq[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
            if (i == 3) PSW_bits = 2'b10;
            if (i == 6) begin
                checks++;
                if (ctrl !== br_exp || GPR_select !== 3'd1)
                    begin errors++; $display("FAIL branch_strobes got %0h/%0d want %0h/1", ctrl, GPR_select, br_exp); end
            end
        end
        PSW_bits = 2'b00;
    endtask

    task automatic test_shift;
        logic [15:0] instr_v [2];
        logic [4:0]  exp_s [2];
        instr_v = '{16'h5000, 16'h5001};
        exp_s   = '{S_E5_L, S_E5_R};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            instruction = instr_v[k];
            do_reset();
            for (int i = 0; i < 4; i++) tick();
            checks++;
            if (state_dbg !== exp_s[k] || ALU_control !== 3'd5)
                begin errors++; $display("FAIL shift[%0d] got %0d/%0d want %0d/5", k, state_dbg, ALU_control, exp_s[k]); end
        end
    endtask

    task automatic test_uart_timeout;
        instruction = 16'hE000; mem_ready = 1'b1; uart_done = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (state_dbg !== S_E14_1) begin errors++; $display("FAIL uart_entry got %0d want %0d", state_dbg, S_E14_1); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (state_dbg !== S_WAIT || uart_timeout !== 1'b0)
                begin errors++; $display("FAIL uart_wait[%0d] got %0d tmo=%0b want %0d tmo=0", i, state_dbg, uart_timeout, S_WAIT); end
        end
        tick();
        checks++;
        if (state_dbg !== S_HALT || halted !== 1'b1 || uart_timeout !== 1'b1 || ctrl !== 20'd0)
            begin errors++; $display("FAIL uart_abort got %0d h=%0b tmo=%0b ctrl=%0h want %0d 1 1 0", state_dbg, halted, uart_timeout, ctrl, S_HALT); end
        dbg_resume = 1'b1; tick(); dbg_resume = 1'b0;
        checks++;
        if (state_dbg !== S_F1 || uart_timeout !== 1'b0 || halted !== 1'b0)
            begin errors++; $display("FAIL uart_resume got %0d tmo=%0b h=%0b want %0d 0 0", state_dbg, uart_timeout, halted, S_F1); end
    endtask

    task automatic test_uart_done;
        instruction = 16'hE000; mem_ready = 1'b1; uart_done = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        uart_done = 1'b1; mem_ready = 1'b0;
        tick();
        uart_done = 1'b0;
        checks++;
        if (state_dbg !== S_E14_3 || uart_timeout !== 1'b0 || ctrl[C_RAM_WR] !== 1'b1)
            begin errors++; $display("FAIL uart_done_prio got %0d tmo=%0b wr=%0b want %0d 0 1", state_dbg, uart_timeout, ctrl[C_RAM_WR], S_E14_3); end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (state_dbg !== S_F1) begin errors++; $display("FAIL uart_done_end got %0d want %0d", state_dbg, S_F1); end
    endtask

    task automatic test_reset_mid_stall;
        instruction = 16'h8000; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (state_dbg !== S_E8_2 || ctrl[C_RAM_WR] !== 1'b1)
            begin errors++; $display("FAIL store_entry got %0d wr=%0b want %0d wr=1", state_dbg, ctrl[C_RAM_WR], S_E8_2); end
        mem_ready = 1'b0; dbg_resume = 1'b1;
        tick();
        dbg_resume = 1'b0;
        checks++;
        if (state_dbg !== S_E8_2 || ctrl[C_RAM_WR] !== 1'b1)
            begin errors++; $display("FAIL store_hold got %0d wr=%0b want %0d wr=1", state_dbg, ctrl[C_RAM_WR], S_E8_2); end
        reset = 1'b0;
        tick();
        checks++;
        if (state_dbg !== S_IDLE || ctrl !== 20'd0)
            begin errors++; $display("FAIL stall_reset got %0d ctrl=%0h want 0 0", state_dbg, ctrl); end
        reset = 1'b1; mem_ready = 1'b1;
    endtask

    task automatic test_step_halt;
        logic [4:0] exp_s [5];
        exp_s = '{S_F1, S_F2, S_F3, S_E11_1, S_HALT};
        instruction = 16'hB000; mem_ready = 1'b1; dbg_step = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state_dbg !== exp_s[i]) begin errors++; $display("FAIL step_seq[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); end
        end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL step_halted got %0b want 1", halted); end
        dbg_step = 1'b0; dbg_resume = 1'b1; tick(); dbg_resume = 1'b0;
        checks++;
        if (state_dbg !== S_F1) begin errors++; $display("FAIL step_resume got %0d want %0d", state_dbg, S_F1); end
        instruction = 16'h0000;
        tick(); tick(); tick();
        checks++;
        if (state_dbg !== S_HALT) begin errors++; $display("FAIL zero_halt got %0d want %0d", state_dbg, S_HALT); end
        dbg_resume = 1'b1; tick(); tick(); dbg_resume = 1'b0;
        checks++;
        if (state_dbg !== S_HALT || halted !== 1'b1)
            begin errors++; $display("FAIL zero_resume_ignored got %0d h=%0b want %0d 1", state_dbg, halted, S_HALT); end
        reset = 1'b0; tick();
        checks++;
        if (state_dbg !== S_IDLE) begin errors++; $display("FAIL zero_reset got %0d want 0", state_dbg); end
        reset = 1'b1; tick();
        checks++;
        if (state_dbg !== S_F1) begin errors++; $display("FAIL zero_recover got %0d want %0d", state_dbg, S_F1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_stall();
        test_branch();
        test_shift();
        test_uart_timeout();
        test_uart_done();
        test_reset_mid_stall();
        test_step_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
